// File: rtl/adc128s_pkg.sv
// Shared constants for the ADC128S SPI slave model: channel indices, frame and data widths.
package adc128s_pkg;

  localparam int unsigned DATA_W     = 12;
  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned CNT_W      = 5;
  localparam int unsigned CH_W       = 3;
  localparam int unsigned CMD_CH_MSB = 13;
  localparam int unsigned CMD_CH_LSB = 11;

  typedef logic [CH_W-1:0] ch_t;

  localparam ch_t CH_LD_LFT  = 3'd0;
  localparam ch_t CH_LD_RGHT = 3'd4;
  localparam ch_t CH_STEER   = 3'd5;
  localparam ch_t CH_BATT    = 3'd6;

endpackage

// File: rtl/adc128s_fc_if.sv
// SPI pin bundle between the A2D master and the ADC128S slave model.
interface adc128s_fc_if;
  logic SS_n;
  logic SCLK;
  logic MOSI;
  logic MISO;

  modport master (output SS_n, output SCLK, output MOSI, input MISO);
  modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/adc_spi_sync.sv
// Two-flop synchronizer for the SPI pins plus edge strobes for SCLK and SS_n
// (detected against a third, delayed flop).
module adc_spi_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic ss_n_pin,
  input  logic sclk_pin,
  input  logic mosi_pin,
  output logic ss_n_s,
  output logic ss_n_d,
  output logic mosi_s,
  output logic sclk_rise_c,
  output logic sclk_fall_c,
  output logic ss_fall_c,
  output logic ss_rise_c
);

  logic ss_n_m, sclk_m, sclk_s, sclk_d, mosi_m;

  // Reset to idle bus: deselected, SCLK low, MOSI low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_n_m <= 1'b1;
      ss_n_s <= 1'b1;
      ss_n_d <= 1'b1;
      sclk_m <= 1'b0;
      sclk_s <= 1'b0;
      sclk_d <= 1'b0;
      mosi_m <= 1'b0;
      mosi_s <= 1'b0;
    end else begin
      ss_n_m <= ss_n_pin;
      ss_n_s <= ss_n_m;
      ss_n_d <= ss_n_s;
      sclk_m <= sclk_pin;
      sclk_s <= sclk_m;
      sclk_d <= sclk_s;
      mosi_m <= mosi_pin;
      mosi_s <= mosi_m;
    end
  end

  assign sclk_rise_c = sclk_s & ~sclk_d;
  assign sclk_fall_c = ~sclk_s & sclk_d;
  assign ss_fall_c   = ~ss_n_s & ss_n_d;
  assign ss_rise_c   = ss_n_s & ~ss_n_d;

endmodule

// File: rtl/adc128s_fc.sv
// ADC128S SPI slave model: each 16-bit frame returns the previously commanded
// channel's 12-bit sample and latches the next channel from RX[13:11].
module adc128s_fc
  import adc128s_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  adc128s_fc_if.slave       spi,
  input  logic [DATA_W-1:0] ld_cell_lft,
  input  logic [DATA_W-1:0] ld_cell_rght,
  input  logic [DATA_W-1:0] steerPot,
  input  logic [DATA_W-1:0] batt
);

  logic ss_n_s, ss_n_d, mosi_s;
  logic sclk_rise_c, sclk_fall_c, ss_fall_c, ss_rise_c;

  logic [FRAME_BITS-1:0] tx_q, tx_nxt;
  logic [FRAME_BITS-1:0] rx_q, rx_nxt;
  logic [CNT_W-1:0]      cnt_q, cnt_nxt;
  ch_t                   ch_q, ch_nxt;
  logic                  miso_q, miso_nxt;
  logic [DATA_W-1:0]     ch_data_c;

  adc_spi_sync u_sync (
    .clk         (clk),
    .rst_n       (rst_n),
    .ss_n_pin    (spi.SS_n),
    .sclk_pin    (spi.SCLK),
    .mosi_pin    (spi.MOSI),
    .ss_n_s      (ss_n_s),
    .ss_n_d      (ss_n_d),
    .mosi_s      (mosi_s),
    .sclk_rise_c (sclk_rise_c),
    .sclk_fall_c (sclk_fall_c),
    .ss_fall_c   (ss_fall_c),
    .ss_rise_c   (ss_rise_c)
  );

  // Channel mux; unpopulated channels read as zero
  always_comb begin
    ch_data_c = '0;
    case (ch_q)
      CH_LD_LFT:  ch_data_c = ld_cell_lft;
      CH_LD_RGHT: ch_data_c = ld_cell_rght;
      CH_STEER:   ch_data_c = steerPot;
      CH_BATT:    ch_data_c = batt;
      default:    ch_data_c = '0;
    endcase
  end

  // Frame sequencing; the delayed SS_n level gates SCLK edges so an edge
  // coinciding with SS_n rise is still taken before the frame closes
  always_comb begin
    tx_nxt  = tx_q;
    rx_nxt  = rx_q;
    cnt_nxt = cnt_q;
    ch_nxt  = ch_q;
    if (ss_fall_c) begin
      tx_nxt  = {(FRAME_BITS - DATA_W)'(0), ch_data_c};
      rx_nxt  = '0;
      cnt_nxt = '0;
    end else if (!ss_n_d) begin
      if (sclk_rise_c && (cnt_q < CNT_W'(FRAME_BITS))) begin
        rx_nxt  = {rx_q[FRAME_BITS-2:0], mosi_s};
        cnt_nxt = cnt_q + CNT_W'(1);
      end
      if (sclk_fall_c)
        tx_nxt = {tx_q[FRAME_BITS-2:0], 1'b0};
      if (ss_rise_c && (cnt_nxt == CNT_W'(FRAME_BITS)))
        ch_nxt = rx_nxt[CMD_CH_MSB:CMD_CH_LSB];
    end
    miso_nxt = ss_n_s ? 1'b0 : tx_nxt[FRAME_BITS-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_q   <= '0;
      rx_q   <= '0;
      cnt_q  <= '0;
      ch_q   <= CH_LD_LFT;
      miso_q <= 1'b0;
    end else begin
      tx_q   <= tx_nxt;
      rx_q   <= rx_nxt;
      cnt_q  <= cnt_nxt;
      ch_q   <= ch_nxt;
      miso_q <= miso_nxt;
    end
  end

  assign spi.MISO = miso_q;

endmodule

// File: tb/tb_adc128s_fc.sv
// Self-checking bench for adc128s_fc: directed scenarios followed by random
// frames, checked against a channel-pending model of the converter.
module tb_adc128s_fc;

  logic        clk;
  logic        rst_n;
  logic [11:0] ld_cell_lft, ld_cell_rght, steerPot, batt;
  int          n_cmp;
  int          n_err;
  logic [2:0]  m_ch;

  adc128s_fc_if spi_if ();

  adc128s_fc dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .spi          (spi_if),
    .ld_cell_lft  (ld_cell_lft),
    .ld_cell_rght (ld_cell_rght),
    .steerPot     (steerPot),
    .batt         (batt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_data(input logic [2:0] ch);
    case (ch)
      3'd0:    return {4'h0, ld_cell_lft};
      3'd4:    return {4'h0, ld_cell_rght};
      3'd5:    return {4'h0, steerPot};
      3'd6:    return {4'h0, batt};
      default: return 16'h0000;
    endcase
  endfunction

  task automatic rand_data();
    ld_cell_lft  = 12'($urandom);
    ld_cell_rght = 12'($urandom);
    steerPot     = 12'($urandom);
    batt         = 12'($urandom);
  endtask

  // One SPI mode-0 frame of nbits clocks; MISO sampled just before each SCLK rise
  task automatic frame(input string tag, input logic [15:0] cmd, input int nbits,
                       input bit mid_rand);
    logic [15:0] exp;
    logic [15:0] resp;
    int          sh;
    exp  = model_data(m_ch);
    resp = '0;
    spi_if.SS_n = 1'b0;
    wait_clk(10);
    for (int i = 0; i < nbits; i++) begin
      spi_if.MOSI = cmd[15-i];
      wait_clk(10);
      resp[15-i] = spi_if.MISO;
      spi_if.SCLK = 1'b1;
      if (mid_rand && i == 8) rand_data();
      wait_clk(10);
      spi_if.SCLK = 1'b0;
    end
    wait_clk(10);
    spi_if.SS_n = 1'b1;
    spi_if.MOSI = 1'b0;
    wait_clk(10);
    chk({tag, "_idle"}, {15'h0, spi_if.MISO}, 16'h0000);
    sh = 16 - nbits;
    chk({tag, "_resp"}, resp >> sh, exp >> sh);
    if (nbits == 16) m_ch = cmd[13:11];
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    m_ch  = 3'd0;
    spi_if.SS_n = 1'b1;
    spi_if.SCLK = 1'b0;
    spi_if.MOSI = 1'b0;
    ld_cell_lft  = 12'h123;
    ld_cell_rght = 12'h000;
    steerPot     = 12'hE00;
    batt         = 12'h000;
    rst_n = 1'b0;
    wait_clk(4);
    chk("reset_miso", {15'h0, spi_if.MISO}, 16'h0000);
    rst_n = 1'b1;
    wait_clk(4);

    // Default channel 0 then commanded steering pot
    frame("f1_ch0_default", 16'h2800, 16, 1'b0);
    frame("f2_ch5",         16'h0000, 16, 1'b0);

    ld_cell_lft  = 12'h300;
    ld_cell_rght = 12'h2A5;
    batt         = 12'hFFF;
    frame("ch0_lft",  16'h2000, 16, 1'b0);
    frame("ch4_rght", 16'h3000, 16, 1'b0);
    frame("ch6_batt", 16'h1800, 16, 1'b0);
    frame("ch3_zero", 16'h2800, 16, 1'b0);

    // Sample taken at SS_n fall of the response frame
    steerPot = 12'hA00;
    wait_clk(5);
    steerPot = 12'h200;
    frame("steer_fresh", 16'h2800, 16, 1'b0);
    frame("steer_midchg", 16'h2800, 16, 1'b1);

    // Aborted frame keeps pending channel 5
    frame("abort8", 16'h3000, 8, 1'b0);
    frame("after_abort", 16'h3000, 16, 1'b0);

    // Reset in mid-frame while MISO is high
    batt = 12'hFFF;
    spi_if.SS_n = 1'b0;
    wait_clk(10);
    for (int i = 0; i < 6; i++) begin
      wait_clk(10);
      spi_if.SCLK = 1'b1;
      wait_clk(10);
      spi_if.SCLK = 1'b0;
    end
    wait_clk(10);
    chk("pre_reset_miso", {15'h0, spi_if.MISO}, 16'h0001);
    rst_n = 1'b0;
    #1;
    chk("reset_async_miso", {15'h0, spi_if.MISO}, 16'h0000);
    spi_if.SS_n = 1'b1;
    spi_if.SCLK = 1'b0;
    m_ch = 3'd0;
    wait_clk(5);
    rst_n = 1'b1;
    wait_clk(5);
    frame("post_reset_ch0", 16'h0000, 16, 1'b0);

    // Random frames, occasional aborts and mid-frame input changes
    for (int k = 0; k < 40; k++) begin
      int nb;
      rand_data();
      nb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 15)) : 16;
      frame($sformatf("rnd%0d", k), 16'($urandom), nb, 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
